// File: rtl/mult_pkg.sv
// Shared widths and types for the two-lane multiplier scheduler.
// rr_wrap folds an index back into range after adding less than one full NREQ turn.
package mult_pkg;

  localparam int MULT_OPW   = 8;
  localparam int MULT_RESW  = 16;
  localparam int MULT_LANES = 2;

  typedef logic signed [MULT_OPW-1:0]  mult_op_t;
  typedef logic signed [MULT_RESW-1:0] mult_res_t;

  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin search: first and second valid requester at or after ptr.
module mult_rr_pick
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic            first_found,
  output logic [IDW-1:0]  first_idx,
  output logic            second_found,
  output logic [IDW-1:0]  second_idx
);

  always_comb begin
    logic [IDW-1:0] sel;
    first_found  = 1'b0;
    first_idx    = '0;
    second_found = 1'b0;
    second_idx   = '0;
    sel          = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IDW'(rr_wrap(int'(ptr) + k, NREQ));
      if (valid[sel]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = sel;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = sel;
        end
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing a two-lane signed 8x8 multiplier between NREQ requesters.
// Each lane holds its second operand and id until the tagged product is consumed.
//
//   lane state | meaning
//   LANE_FREE  | no result pending, rsp_valid low
//   LANE_HELD  | product presented on rsp_data, operand and id frozen until accepted
module mult_sched
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*MULT_OPW-1:0]        req_a,
  input  logic [NREQ*MULT_OPW-1:0]        req_b,
  output logic [NREQ-1:0]                 req_ready,
  output logic [3:0]                      mul_en,
  output logic [MULT_OPW-1:0]             mul_a,
  output logic [MULT_OPW-1:0]             mul_b,
  output logic [MULT_OPW-1:0]             mul_c,
  output logic [MULT_OPW-1:0]             mul_d,
  input  logic [MULT_RESW-1:0]            mul_res0,
  input  logic [MULT_RESW-1:0]            mul_res1,
  output logic [MULT_LANES-1:0]           rsp_valid,
  input  logic [MULT_LANES-1:0]           rsp_ready,
  output logic [MULT_LANES*IDW-1:0]       rsp_id,
  output logic [MULT_LANES*MULT_RESW-1:0] rsp_data
);

  localparam logic [0:0] LANE_FREE = 1'b0;
  localparam logic [0:0] LANE_HELD = 1'b1;

  logic [0:0]            lane_st   [MULT_LANES];
  logic [IDW-1:0]        lane_id   [MULT_LANES];
  logic [IDW-1:0]        rr_ptr;

  logic                  first_found, second_found;
  logic [IDW-1:0]        first_idx, second_idx;

  logic [MULT_LANES-1:0] avail;
  logic [MULT_LANES-1:0] grant;
  logic [IDW-1:0]        grant_idx [MULT_LANES];
  logic [IDW-1:0]        last_idx;
  mult_op_t              grant_a   [MULT_LANES];
  mult_op_t              grant_b   [MULT_LANES];

  mult_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid        (req_valid),
    .ptr          (rr_ptr),
    .first_found  (first_found),
    .first_idx    (first_idx),
    .second_found (second_found),
    .second_idx   (second_idx)
  );

  // Reset gates availability so nothing is granted while rst_n is low.
  always_comb begin
    for (int l = 0; l < MULT_LANES; l++) begin
      avail[l] = rst_n & ((lane_st[l] == LANE_FREE) | rsp_ready[l]);
    end
    grant        = '0;
    grant_idx[0] = first_idx;
    grant_idx[1] = first_idx;
    last_idx     = first_idx;
    if (avail[0]) begin
      grant[0]     = first_found;
      grant[1]     = first_found & second_found & avail[1];
      grant_idx[1] = second_idx;
      if (grant[1]) last_idx = second_idx;
    end else begin
      grant[1] = first_found & avail[1];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int l = 0; l < MULT_LANES; l++) begin
      grant_a[l] = '0;
      grant_b[l] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      for (int l = 0; l < MULT_LANES; l++) begin
        if (grant[l] && (grant_idx[l] == IDW'(i))) begin
          req_ready[i] = 1'b1;
          grant_a[l]   = req_a[i*MULT_OPW +: MULT_OPW];
          grant_b[l]   = req_b[i*MULT_OPW +: MULT_OPW];
        end
      end
    end
  end

  assign mul_en = {2'b00, grant};
  assign mul_a  = grant_a[0];
  assign mul_c  = grant_a[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < MULT_LANES; l++) begin
        lane_st[l] <= LANE_FREE;
        lane_id[l] <= '0;
      end
      mul_b  <= '0;
      mul_d  <= '0;
      rr_ptr <= '0;
    end else begin
      for (int l = 0; l < MULT_LANES; l++) begin
        if (grant[l]) begin
          lane_st[l] <= LANE_HELD;
          lane_id[l] <= grant_idx[l];
        end else if (rsp_ready[l]) begin
          lane_st[l] <= LANE_FREE;
        end
      end
      if (grant[0]) mul_b <= grant_b[0];
      if (grant[1]) mul_d <= grant_b[1];
      if (|grant) rr_ptr <= IDW'(rr_wrap(int'(last_idx) + 1, NREQ));
    end
  end

  always_comb begin
    for (int l = 0; l < MULT_LANES; l++) begin
      rsp_valid[l] = (lane_st[l] == LANE_HELD);
    end
  end

  assign rsp_id   = {lane_id[1], lane_id[0]};
  assign rsp_data = {mul_res1, mul_res0};

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: a lane-level reference model predicts grants and
// queues expected (id, product) per lane; a negedge monitor pops on each response handshake.
module tb_mult_sched;
  import mult_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [NREQ-1:0]  req_ready;
  logic [3:0]       mul_en;
  logic [7:0]       mul_a, mul_b, mul_c, mul_d;
  logic [15:0]      mul_res0, mul_res1;
  logic [1:0]       rsp_valid, rsp_ready;
  logic [2*IDW-1:0] rsp_id;
  logic [31:0]      rsp_data;

  always #5 clk = ~clk;

  mult_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_d     (mul_d),
    .mul_res0  (mul_res0),
    .mul_res1  (mul_res1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  // Behavioural multiplier: first operand captured on mul_en, second held by the DUT.
  logic [7:0] opa0 = 8'h00, opa1 = 8'h00;
  always @(posedge clk) begin
    if (mul_en[0]) opa0 <= mul_a;
    if (mul_en[1]) opa1 <= mul_c;
  end
  assign mul_res0 = {{8{opa0[7]}}, opa0} * {{8{mul_b[7]}}, mul_b};
  assign mul_res1 = {{8{opa1[7]}}, opa1} * {{8{mul_d[7]}}, mul_d};

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  bit [1:0] held = 2'b00;
  int       ptr  = 0;

  logic [NREQ*8-1:0] sa, sb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setop(input int i, input logic [7:0] a, input logic [7:0] b);
    sa[i*8 +: 8] = a;
    sb[i*8 +: 8] = b;
  endtask

  // One clock of stimulus plus model prediction of this cycle's grants.
  task automatic step(input logic [NREQ-1:0] v, input logic [1:0] rr);
    int cand[$];
    int lanes[$];
    logic [NREQ-1:0] er;
    logic [3:0] ee;
    int n;
    int last;
    @(posedge clk);
    #1;
    req_valid = v;
    req_a     = sa;
    req_b     = sb;
    rsp_ready = rr;
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) cand.push_back((ptr + k) % NREQ);
    end
    for (int l = 0; l < 2; l++) begin
      if (!held[l] || rr[l]) lanes.push_back(l);
    end
    n = (cand.size() < lanes.size()) ? cand.size() : lanes.size();
    er = '0;
    ee = '0;
    last = -1;
    chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, held});
    for (int j = 0; j < n; j++) begin
      int r;
      int l;
      logic [7:0] a;
      logic [7:0] b;
      int p;
      exp_t e;
      r = cand[j];
      l = lanes[j];
      a = sa[r*8 +: 8];
      b = sb[r*8 +: 8];
      p = int'($signed(a)) * int'($signed(b));
      er[r] = 1'b1;
      ee[l] = 1'b1;
      last = r;
      e.id = IDW'(r);
      e.data = 16'(p);
      if (l == 0) begin
        chk("mul_a", {24'b0, mul_a}, {24'b0, a});
        q0.push_back(e);
      end else begin
        chk("mul_c", {24'b0, mul_c}, {24'b0, a});
        q1.push_back(e);
      end
    end
    chk("req_ready", {28'b0, req_ready}, {28'b0, er});
    chk("mul_en", {28'b0, mul_en}, {28'b0, ee});
    for (int l = 0; l < 2; l++) held[l] = ee[l] || (held[l] && !rr[l]);
    if (last >= 0) ptr = (last + 1) % NREQ;
  endtask

  task automatic check_lane(input int l);
    exp_t e;
    if (l == 0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane0 response: got id %0d data 0x%0h expected none", rsp_id[IDW-1:0], rsp_data[15:0]);
        return;
      end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane1 response: got id %0d data 0x%0h expected none", rsp_id[2*IDW-1:IDW], rsp_data[31:16]);
        return;
      end
      e = q1.pop_front();
    end
    chk("rsp_id", {30'b0, rsp_id[l*IDW +: IDW]}, {30'b0, e.id});
    chk("rsp_data", {16'b0, rsp_data[l*16 +: 16]}, {16'b0, e.data});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid[0] && rsp_ready[0]) check_lane(0);
      if (rsp_valid[1] && rsp_ready[1]) check_lane(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 2'b00;
    sa = '0;
    sb = '0;
    #2;
    chk("reset rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("reset req_ready", {28'b0, req_ready}, 32'd0);
    chk("reset mul_en", {28'b0, mul_en}, 32'd0);
    chk("reset mul_b", {24'b0, mul_b}, 32'd0);
    chk("reset mul_d", {24'b0, mul_d}, 32'd0);
    chk("reset rsp_id", {28'b0, rsp_id}, 32'd0);
    req_valid = '0;
    #10 rst_n = 1'b1;

    // Single request: 3 * -4
    setop(0, 8'h03, 8'hFC);
    step(4'b0001, 2'b11);
    chk("single req_ready", {28'b0, req_ready}, 32'h1);

    // Dual issue: (-128 * -128) and (127 * -1)
    sa = '0; sb = '0;
    setop(1, 8'h80, 8'h80);
    setop(2, 8'h7F, 8'hFF);
    step(4'b0110, 2'b11);
    chk("single rsp_id", {30'b0, rsp_id[1:0]}, 32'd0);
    chk("single rsp_data", {16'b0, rsp_data[15:0]}, 32'h0000FFF4);
    chk("dual req_ready", {28'b0, req_ready}, 32'h6);
    step(4'b0000, 2'b11);
    chk("dual rsp_valid", {30'b0, rsp_valid}, 32'h3);
    chk("dual rsp_id", {28'b0, rsp_id}, 32'h9);
    chk("dual rsp_data", rsp_data, 32'hFF81_4000);

    // Backpressure on lane 0 holding 2 * 3
    sa = '0; sb = '0;
    setop(0, 8'h02, 8'h03);
    step(4'b0001, 2'b11);
    for (int i = 0; i < 5; i++) begin
      setop(1, 8'($urandom), 8'($urandom));
      step(4'b0010, 2'b10);
      chk("bp hold data", {16'b0, rsp_data[15:0]}, 32'd6);
      chk("bp lane0 idle", {31'b0, mul_en[0]}, 32'd0);
    end
    setop(1, 8'($urandom), 8'($urandom));
    step(4'b0010, 2'b11);
    chk("bp lane0 reuse", {28'b0, mul_en}, 32'h1);

    // Reset with both lanes holding results
    sa = $urandom; sb = $urandom;
    step(4'b0011, 2'b11);
    step(4'b0000, 2'b00);
    chk("pre-reset held", {30'b0, rsp_valid}, 32'h3);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("midreset rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("midreset req_ready", {28'b0, req_ready}, 32'd0);
    chk("midreset mul_en", {28'b0, mul_en}, 32'd0);
    q0.delete();
    q1.delete();
    held = 2'b00;
    ptr = 0;
    repeat (2) @(posedge clk);
    req_valid = '0;
    #3 rst_n = 1'b1;

    // Fairness: all requesters valid, grants alternate (0,1) then (2,3)
    for (int i = 0; i < 6; i++) begin
      sa = $urandom; sb = $urandom;
      step(4'b1111, 2'b11);
      chk("fair grants", {28'b0, req_ready}, (i % 2 == 1) ? 32'hC : 32'h3);
    end

    // Randomised traffic
    for (int i = 0; i < 10000; i++) begin
      sa = $urandom;
      sb = $urandom;
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    repeat (3) step(4'b0000, 2'b11);
    chk("lane0 drained", q0.size(), 32'd0);
    chk("lane1 drained", q1.size(), 32'd0);
    chk("final rsp_valid", {30'b0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
